// File: rtl/sync_fifo_multiport.sv
// sync_fifo_multiport: multi-push/multi-pop FIFO with a combinational read window,
// presented entry-major or lane-transposed for the 2x2 interpolation kernel.
module sync_fifo_multiport #(
  parameter int DW         = 8,
  parameter int LANES      = 2,
  parameter int WR_MAX     = 3,
  parameter int RD_MAX     = 2,
  parameter int FIFO_DEPTH = 64,
  parameter int AFULL_TH   = 4,
  parameter int LANE_MAJOR = 1,
  localparam int EW  = DW * LANES,
  localparam int AW  = $clog2(FIFO_DEPTH),
  localparam int CW  = AW + 1,
  localparam int WNW = $clog2(WR_MAX + 1),
  localparam int RNW = $clog2(RD_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WNW-1:0]       wr_num_i,
  input  logic [WR_MAX*EW-1:0] wr_data_i,
  input  logic [RNW-1:0]       rd_num_i,
  output logic [RD_MAX*EW-1:0] rd_data_o,
  output logic [AW:0]          count_o,
  output logic [AW:0]          free_cnt_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 ovf_err_o,
  output logic                 udf_err_o
);
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, wr_n, rd_n, wr_acc, rd_acc;
  logic          ovf_q, udf_q;
  assign wr_n          = CW'(wr_num_i);
  assign rd_n          = CW'(rd_num_i);
  assign count_o       = count_q;
  assign free_cnt_o    = CW'(FIFO_DEPTH) - count_q;
  assign full_o        = count_q == CW'(FIFO_DEPTH);
  assign empty_o       = count_q == '0;
  assign almost_full_o = int'(free_cnt_o) < AFULL_TH;
  assign ovf_err_o     = ovf_q;
  assign udf_err_o     = udf_q;
  // Acceptance looks only at pre-edge occupancy, so rd_num never feeds write acceptance.
  always_comb begin
    wr_acc   = (wr_n <= CW'(WR_MAX) && wr_n <= free_cnt_o) ? wr_n : '0;
    rd_acc   = (rd_n <= CW'(RD_MAX) && rd_n <= count_q) ? rd_n : '0;
    wr_ptr_d = wr_ptr_q + wr_acc[AW-1:0];
    rd_ptr_d = rd_ptr_q + rd_acc[AW-1:0];
    count_d  = count_q + wr_acc - rd_acc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < WR_MAX; i++)
        if (CW'(i) < wr_acc) mem_q[wr_ptr_q + AW'(i)] <= wr_data_i[(WR_MAX-i)*EW-1 -: EW];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= wr_acc != wr_n;
      udf_q    <= rd_acc != rd_n;
    end
  end
  // Lane k of window entry j lands at chunk k*RD_MAX+j (transposed) or j*LANES+k, counted from the MSB.
  always_comb begin
    rd_data_o = '0;
    for (int j = 0; j < RD_MAX; j++)
      for (int k = 0; k < LANES; k++)
        rd_data_o[(RD_MAX*LANES - (LANE_MAJOR != 0 ? k*RD_MAX + j : j*LANES + k))*DW-1 -: DW] =
          mem_q[rd_ptr_q + AW'(j)][(LANES-k)*DW-1 -: DW];
  end
endmodule

// File: tb/tb_sync_fifo_multiport.sv
// tb_sync_fifo_multiport: directed and random-stream checks of both read orderings
// against a queue reference model.
module tb_sync_fifo_multiport;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wr_num = '0;
  logic [47:0] wr_data = '0;
  logic [1:0]  rd_num = '0;
  logic [31:0] rd_lm, rd_em;
  logic [6:0]  count, free_cnt, count_e, free_e;
  logic        full, empty, afull, ovf, udf;
  logic        full_e, empty_e, afull_e, ovf_e, udf_e;
  int          total = 0, bad = 0;
  logic [15:0] q[$];
  logic [15:0] seq = 16'h0100;
  bit          exp_ovf = 0, exp_udf = 0;

  always #5 clk = ~clk;

  sync_fifo_multiport #(.LANE_MAJOR(1)) dut_lm (
    .clk(clk), .rst_n(rst_n), .wr_num_i(wr_num), .wr_data_i(wr_data), .rd_num_i(rd_num),
    .rd_data_o(rd_lm), .count_o(count), .free_cnt_o(free_cnt), .full_o(full), .empty_o(empty),
    .almost_full_o(afull), .ovf_err_o(ovf), .udf_err_o(udf));

  sync_fifo_multiport #(.LANE_MAJOR(0)) dut_em (
    .clk(clk), .rst_n(rst_n), .wr_num_i(wr_num), .wr_data_i(wr_data), .rd_num_i(rd_num),
    .rd_data_o(rd_em), .count_o(count_e), .free_cnt_o(free_e), .full_o(full_e), .empty_o(empty_e),
    .almost_full_o(afull_e), .ovf_err_o(ovf_e), .udf_err_o(udf_e));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] nwd();
    logic [47:0] d;
    for (int i = 0; i < 3; i++) begin
      seq = seq + 16'h0101;
      d[(3-i)*16-1 -: 16] = seq;
    end
    return d;
  endfunction

  task automatic check_all();
    int n = q.size();
    chk("count", int'(count), n);
    chk("count_em", int'(count_e), n);
    chk("free_cnt", int'(free_cnt), 64 - n);
    chk("full", int'(full), int'(n == 64));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(afull), int'(64 - n < 4));
    chk("ovf_err", int'(ovf), int'(exp_ovf));
    chk("udf_err", int'(udf), int'(exp_udf));
    chk("ovf_err_em", int'(ovf_e), int'(exp_ovf));
    chk("udf_err_em", int'(udf_e), int'(exp_udf));
    for (int j = 0; j < 2; j++)
      if (j < n) begin
        chk("rd_lane_major", int'({rd_lm[31-8*j -: 8], rd_lm[15-8*j -: 8]}), int'(q[j]));
        chk("rd_entry_major", int'(rd_em[31-16*j -: 16]), int'(q[j]));
      end
  endtask

  task automatic step(input int wn, input int rn, input logic [47:0] wd);
    int  n = q.size();
    bit  wa = (wn <= 3) && (wn <= 64 - n);
    bit  ra = (rn <= 2) && (rn <= n);
    wr_num  = 2'(wn);
    rd_num  = 2'(rn);
    wr_data = wd;
    @(posedge clk);
    #1;
    wr_num = '0;
    rd_num = '0;
    if (ra) for (int i = 0; i < rn; i++) void'(q.pop_front());
    if (wa) for (int i = 0; i < wn; i++) q.push_back(wd[(3-i)*16-1 -: 16]);
    exp_ovf = !wa;
    exp_udf = !ra;
    check_all();
  endtask

  initial begin
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_free", int'(free_cnt), 64);
    chk("rst_afull", int'(afull), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_udf", int'(udf), 0);
    chk("rst_rd_lm", int'(rd_lm), 0);
    chk("rst_rd_em", int'(rd_em), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    step(3, 0, 48'h1111_2222_3333);
    chk("first_count", int'(count), 3);
    chk("first_rd_lm", int'(rd_lm), 32'h1122_1122);
    chk("first_rd_em", int'(rd_em), 32'h1111_2222);

    for (int i = 0; i < 19; i++) step(3, 0, nwd());
    step(2, 0, nwd());
    chk("fill62_count", int'(count), 62);
    step(3, 0, 48'hDEAD_BEEF_CAFE);
    chk("ovf_pulse", int'(ovf), 1);
    chk("ovf_count", int'(count), 62);
    step(0, 0, nwd());
    chk("ovf_once", int'(ovf), 0);
    step(2, 0, nwd());
    chk("full_flag", int'(full), 1);
    chk("full_free", int'(free_cnt), 0);
    step(0, 1, nwd());
    chk("c63", int'(count), 63);
    step(1, 2, nwd());
    chk("pushpop_count", int'(count), 62);
    chk("pushpop_ovf", int'(ovf), 0);
    chk("pushpop_udf", int'(udf), 0);

    for (int i = 0; i < 30; i++) step(0, 2, nwd());
    step(0, 1, nwd());
    chk("c1", int'(count), 1);
    step(0, 2, nwd());
    chk("udf_pulse", int'(udf), 1);
    chk("udf_count", int'(count), 1);
    step(0, 1, nwd());
    chk("drain_empty", int'(empty), 1);
    step(2, 1, nwd());
    chk("empty_push_udf", int'(udf), 1);
    chk("empty_push_count", int'(count), 2);

    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 3), $urandom_range(0, 3), nwd());
      chk("count_bound", int'(count <= 7'd64), 1);
    end

    while (q.size() > 0) step(0, q.size() >= 2 ? 2 : 1, nwd());
    for (int i = 0; i < 13; i++) step(3, 0, nwd());
    step(1, 0, nwd());
    chk("c40", int'(count), 40);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_empty", int'(empty), 1);
    chk("async_rd_lm", int'(rd_lm), 0);
    chk("async_rd_em", int'(rd_em), 0);
    q.delete();
    exp_ovf = 0;
    exp_udf = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check_all();
    step(3, 0, 48'hABCD_1234_5678);
    chk("resume_rd_lm", int'(rd_lm), 32'hAB12_CD34);
    chk("resume_rd_em", int'(rd_em), 32'hABCD_1234);
    step(0, 2, nwd());
    chk("resume_count", int'(count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
